fp_mul_wb_stage: RTL and testbench
==================================

// Module: fp_mul_wb_stage
// PURPOSE
//   Registered write-back stage directly downstream of the combinational FP32 multiplier.
//   Captures {result, exceptions} through a valid/ready handshake and buffers them in a
//   2-entry skid buffer, giving full throughput and a registered output.
//   Accumulates sticky exception flags (IV,O,U,N,Z) and raises a maskable interrupt.
// PARAMETERS
//   CNT_W   16  width of the optional per-flag saturating event counters
// PORTS
//   clk            in   1   clock; all logic on rising edge
//   rst            in   1   synchronous reset, active-high
//   in_valid       in   1   multiplier result valid
//   in_ready       out  1   stage can accept this cycle
//   in_result      in   32  FP32 product from multiplier
//   in_exc         in   5   multiplier flags [4:IV,3:O,2:U,1:N,0:Z]
//   out_valid      out  1   buffered result valid
//   out_ready      in   1   consumer accepts
//   out_result     out  32  head-of-buffer FP32 result
//   out_exc        out  5   head-of-buffer flags
//   sticky_clr     in   1   clear sticky flags (and counters)
//   exc_mask       in   5   1 = flag does not raise irq
//   sticky_flags   out  5   OR of in_exc over all accepted transfers since clear
//   irq            out  1   registered |(sticky_flags & ~exc_mask)
//   cnt_iv, cnt_ov out  CNT_W  IV / O event counts (present only with FP_EXC_CNT_EN)
// BEHAVIOUR
//   - Reset (rst=1 at edge): buffer empty, out_valid=0, out_result=0, out_exc=0,
//     sticky_flags=0, irq=0, counters=0; in_ready=0 while rst is high.
//   - Accept = in_valid & in_ready; emit = out_valid & out_ready.
//   - Buffer states EMPTY -> ONE (accept) -> TWO (accept, no emit); TWO -> ONE (emit);
//     ONE -> EMPTY (emit, no accept); ONE with accept+emit stays ONE.
//   - in_ready = 1 in EMPTY/ONE, 0 in TWO; derived from registered state only (no
//     combinational path from out_ready to in_ready).
//   - Latency: accepted data appears on out_* the cycle after accept when EMPTY.
//   - Throughput 1/cycle while out_ready=1. Strict FIFO order. out_* stable while
//     out_valid=1 & out_ready=0.
//   - Data passes unmodified; no re-rounding or NaN canonicalisation.
//   - Sticky: on accept, sticky_flags |= in_exc (at accept, not emit).
//     sticky_clr alone -> 0; sticky_clr with simultaneous accept -> sticky_flags = in_exc.
//   - irq updates the cycle after sticky_flags/exc_mask change (one register stage).
//   - Reset mid-stream discards buffered entries; no partial output.
// CONFIGURATION
//   FP_EXC_CNT_EN defined: cnt_iv/cnt_ov count accepts with in_exc[4]/in_exc[3] set,
//     saturate at all-ones, cleared by sticky_clr; clear with simultaneous flagged
//     accept -> count = 1.
//   Not defined: counter logic and cnt_* ports absent; all other behaviour identical.
// TESTING
//   1. Reset 3 cycles -> all outputs 0, in_ready=0; first cycle after -> in_ready=1.
//   2. Push 0x40C00000 exc=5'b00000, out_ready=1 -> next cycle out_valid=1,
//      out_result=0x40C00000, out_exc=0; in_ready stays 1.
//   3. out_ready=0, push A,B,C back-to-back -> in_ready=0 after B, C held;
//      release out_ready -> A,B,C emerge in order, no loss or duplication.
//   4. Push exc 01000 then 00010 -> sticky=01010; sticky_clr with accept exc 10000
//      -> sticky=10000.
//   5. exc_mask=11111, push exc 00001 -> irq=0; mask -> 11110 -> irq=1 next cycle.
//   6. FP_EXC_CNT_EN, CNT_W=2: push 5 results with IV set -> cnt_iv=3 (saturated);
//      sticky_clr -> 0.

Source files
------------

// File: rtl/fp_mul_wb_stage.sv
// Write-back stage behind the FP32 multiplier: 2-entry skid buffer with registered output,
// sticky exception flags and a maskable irq. Optional IV/O event counters under FP_EXC_CNT_EN.
module fp_mul_wb_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic [4:0]       in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_exc,
  input  logic             sticky_clr,
  input  logic [4:0]       exc_mask,
  output logic [4:0]       sticky_flags,
`ifdef FP_EXC_CNT_EN
  output logic [CNT_W-1:0] cnt_iv,
  output logic [CNT_W-1:0] cnt_ov,
`endif
  output logic             irq
);

  // buf_state | meaning
  // EMPTY     | no entries, out_valid low
  // ONE       | head entry on out_*, tail free
  // TWO       | head and tail full, in_ready low
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} buf_state_e;

  buf_state_e  state_q, state_d;
  logic [36:0] head_q, head_d;
  logic [36:0] tail_q, tail_d;
  logic [4:0]  sticky_q, sticky_d;
  logic        irq_q, irq_d;
  logic        accept, emit;
  logic [4:0]  acc_exc;

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready = ~rst & (state_q != TWO);
  assign accept   = in_valid & in_ready;
  assign emit     = (state_q != EMPTY) & out_ready;
  assign acc_exc  = accept ? in_exc : 5'b00000;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = {in_exc, in_result};
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          head_d = {in_exc, in_result};
        end else if (accept) begin
          tail_d  = {in_exc, in_result};
          state_d = TWO;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    sticky_d = sticky_clr ? acc_exc : (sticky_q | acc_exc);
    irq_d    = |(sticky_q & ~exc_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign out_valid    = (state_q != EMPTY);
  assign out_result   = head_q[31:0];
  assign out_exc      = head_q[36:32];
  assign sticky_flags = sticky_q;
  assign irq          = irq_q;

`ifdef FP_EXC_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_iv_q, cnt_iv_d;
  logic [CNT_W-1:0] cnt_ov_q, cnt_ov_d;

  // a clear coinciding with a flagged accept restarts the count at one
  always_comb begin
    cnt_iv_d = cnt_iv_q;
    cnt_ov_d = cnt_ov_q;
    if (sticky_clr) begin
      cnt_iv_d = acc_exc[4] ? CNT_ONE : '0;
      cnt_ov_d = acc_exc[3] ? CNT_ONE : '0;
    end else begin
      if (acc_exc[4] && (cnt_iv_q != CNT_MAX)) cnt_iv_d = cnt_iv_q + CNT_ONE;
      if (acc_exc[3] && (cnt_ov_q != CNT_MAX)) cnt_ov_d = cnt_ov_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_iv_q <= '0;
      cnt_ov_q <= '0;
    end else begin
      cnt_iv_q <= cnt_iv_d;
      cnt_ov_q <= cnt_ov_d;
    end
  end

  assign cnt_iv = cnt_iv_q;
  assign cnt_ov = cnt_ov_q;
`endif

endmodule

// File: tb/tb_fp_mul_wb_stage.sv
// Directed bench for fp_mul_wb_stage: handshake, FIFO order, sticky flags, irq masking,
// reset discard, and (with FP_EXC_CNT_EN) saturating counters at CNT_W=2.
module tb_fp_mul_wb_stage;

`ifdef FP_EXC_CNT_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_exc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_exc;
  logic        sticky_clr;
  logic [4:0]  exc_mask;
  logic [4:0]  sticky_flags;
  logic        irq;
`ifdef FP_EXC_CNT_EN
  logic [CW-1:0] cnt_iv;
  logic [CW-1:0] cnt_ov;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_mul_wb_stage #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_exc       (in_exc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_exc      (out_exc),
    .sticky_clr   (sticky_clr),
    .exc_mask     (exc_mask),
    .sticky_flags (sticky_flags),
`ifdef FP_EXC_CNT_EN
    .cnt_iv       (cnt_iv),
    .cnt_ov       (cnt_ov),
`endif
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle 1 ns so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] VA = 32'h3F80_0000;
  localparam logic [31:0] VB = 32'hC120_0000;
  localparam logic [31:0] VC = 32'h7FC0_0001;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_exc = '0;
    out_ready = 1'b0; sticky_clr = 1'b0; exc_mask = 5'b11111;

    // reset held three cycles
    repeat (3) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_exc", {27'd0, out_exc}, 32'd0);
    chk("rst_sticky", {27'd0, sticky_flags}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single transfer, one-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; in_result = 32'h40C0_0000; in_exc = 5'b00000;
    step();
    in_valid = 1'b0;
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_out_result", out_result, 32'h40C0_0000);
    chk("t2_out_exc", {27'd0, out_exc}, 32'd0);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("t2_drain", {31'd0, out_valid}, 32'd0);

    // back-pressure: fill both entries, hold C, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_result = VA;
    step();
    chk("t3_ready_after_a", {31'd0, in_ready}, 32'd1);
    in_result = VB;
    step();
    chk("t3_ready_after_b", {31'd0, in_ready}, 32'd0);
    in_result = VC;
    step();
    chk("t3_c_held", {31'd0, in_ready}, 32'd0);
    chk("t3_head_a_stable", out_result, VA);
    out_ready = 1'b1;
    #1;
    chk("t3_emit_a", out_result, VA);
    step();
    chk("t3_emit_b", out_result, VB);
    chk("t3_ready_reopen", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("t3_emit_c", out_result, VC);
    chk("t3_c_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("t3_empty", {31'd0, out_valid}, 32'd0);
    chk("t3_sticky_zero", {27'd0, sticky_flags}, 32'd0);

    // sticky accumulation and clear behaviour
    in_valid = 1'b1; in_result = VA; in_exc = 5'b01000;
    step();
    in_exc = 5'b00010; in_result = VB;
    step();
    in_valid = 1'b0;
    chk("t4_out_exc_pass", {27'd0, out_exc}, 32'h02);
    chk("t4_sticky_or", {27'd0, sticky_flags}, 32'h0A);
    sticky_clr = 1'b1; in_valid = 1'b1; in_exc = 5'b10000; in_result = VC;
    step();
    sticky_clr = 1'b0; in_valid = 1'b0;
    chk("t4_clr_with_accept", {27'd0, sticky_flags}, 32'h10);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("t4_clr_alone", {27'd0, sticky_flags}, 32'd0);
    step();

    // irq masking with one-cycle register delay
    in_valid = 1'b1; in_exc = 5'b00001; in_result = VA;
    step();
    in_valid = 1'b0; in_exc = 5'b00000;
    chk("t5_sticky_z", {27'd0, sticky_flags}, 32'h01);
    step();
    chk("t5_irq_masked", {31'd0, irq}, 32'd0);
    exc_mask = 5'b11110;
    #1;
    chk("t5_irq_not_yet", {31'd0, irq}, 32'd0);
    step();
    chk("t5_irq_raised", {31'd0, irq}, 32'd1);
    exc_mask = 5'b11111;
    step();
    chk("t5_irq_remasked", {31'd0, irq}, 32'd0);

    // reset mid-stream discards buffered entries
    out_ready = 1'b0; in_valid = 1'b1; in_exc = 5'b00100; in_result = VB;
    step();
    in_result = VC;
    step();
    in_valid = 1'b0;
    chk("t7_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_rst_result", out_result, 32'd0);
    chk("t7_rst_sticky", {27'd0, sticky_flags}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t7_no_stale", {31'd0, out_valid}, 32'd0);
    chk("t7_ready", {31'd0, in_ready}, 32'd1);

`ifdef FP_EXC_CNT_EN
    // counters saturate at 3 for CNT_W=2
    in_valid = 1'b1; in_exc = 5'b10000; in_result = VA;
    repeat (5) step();
    in_valid = 1'b0; in_exc = 5'b00000;
    chk("t6_cnt_iv_sat", {30'd0, cnt_iv}, 32'd3);
    chk("t6_cnt_ov_zero", {30'd0, cnt_ov}, 32'd0);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("t6_cnt_iv_clr", {30'd0, cnt_iv}, 32'd0);
    sticky_clr = 1'b1; in_valid = 1'b1; in_exc = 5'b01000;
    step();
    sticky_clr = 1'b0; in_valid = 1'b0; in_exc = 5'b00000;
    chk("t6_cnt_ov_clr_acc", {30'd0, cnt_ov}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
